// File: rtl/perf_pkg.sv
// Shared types and register map for the Cohort performance counter block.
// Holds counter_t, address constants, CTRL bit indices and the FSM enum.
package perf_pkg;

    typedef logic [63:0] counter_t;

    // Word addresses of the register map
    localparam int PERF_CTRL_ADDR = 'h00;
    localparam int PERF_EN_ADDR   = 'h01;
    localparam int PERF_OVF_ADDR  = 'h02;
    localparam int PERF_LIVE_BASE = 'h20;
    localparam int PERF_SNAP_BASE = 'h40;

    // CTRL register bits
    localparam int CTRL_RUN_BIT  = 0;
    localparam int CTRL_CLR_BIT  = 1;
    localparam int CTRL_SNAP_BIT = 2;

    typedef enum logic {
        PERF_IDLE = 1'b0,
        PERF_RESP = 1'b1
    } perf_ctrl_state_e;

endpackage

// File: rtl/perf_counter_cell.sv
// One 64-bit event counter with its snapshot copy and overflow sticky bit.
// Ports: clr_i/load_i/inc_i/snap_i controls, ovf_clr_i W1C, cnt_o/snap_o/ovf_o.
// Overflow tracking exists only with COHORT_PERF_OVERFLOW_IRQ_EN defined.
module perf_counter_cell
    import perf_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     clr_i,
    input  logic     load_i,
    input  counter_t load_val_i,
    input  logic     inc_i,
    input  logic     snap_i,
    input  logic     ovf_clr_i,
    output counter_t cnt_o,
    output counter_t snap_o,
    output logic     ovf_o
);

    counter_t cnt_q, cnt_d;
    counter_t snap_q, snap_d;
    logic     wrap;

    // clear beats preload beats increment; losing events are dropped
    always_comb begin
        cnt_d = cnt_q;
        wrap  = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 64'd1;
            wrap  = &cnt_q;
        end
        // snapshot takes the value before this cycle's update
        snap_d = snap_i ? cnt_q : snap_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            snap_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign snap_o = snap_q;

`ifdef COHORT_PERF_OVERFLOW_IRQ_EN
    logic ovf_q, ovf_d;

    // a wrap in the same cycle as a W1C keeps the bit set
    assign ovf_d = (ovf_q & ~ovf_clr_i) | wrap;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_clr_i | wrap;
    assign ovf_o      = 1'b0;
`endif

endmodule

// File: rtl/cohort_perf_ctrl.sv
// Register-mapped controller for a bank of perf counters (run, enable,
// clear, preload, snapshot) behind a valid/ready request/response port.
// Ports: clk_i, rst_ni, event_i, req_* in, resp_* out, ovf_irq_o.
// Optional overflow sticky bits / IRQ: COHORT_PERF_OVERFLOW_IRQ_EN.
module cohort_perf_ctrl
    import perf_pkg::*;
#(
    parameter int NUM_COUNTERS = 8,
    parameter int ADDR_W       = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_COUNTERS-1:0] event_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [ADDR_W-1:0]       req_addr_i,
    input  logic [63:0]             req_wdata_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [63:0]             resp_rdata_o,
    output logic                    resp_err_o,
    output logic                    ovf_irq_o
);

    perf_ctrl_state_e        state_q;
    logic                    req_ready_q;
    logic                    resp_valid_q;
    logic [63:0]             resp_rdata_q;
    logic                    resp_err_q;
    logic                    run_q;
    logic [NUM_COUNTERS-1:0] en_q;

    counter_t                cnt  [NUM_COUNTERS];
    counter_t                snap [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] ovf_vec;

    logic                    acc, wr;
    logic [ADDR_W-1:0]       off_live, off_snap;
    logic                    hit_ctrl, hit_en, hit_ovf;
    logic                    hit_live, hit_snap;
    logic                    clr_all, snap_all;
    logic [NUM_COUNTERS-1:0] load_vec, inc_vec, ovf_clr_vec;
    logic [63:0]             rdata_d;
    logic                    err_d;

    always_comb begin
        acc      = req_valid_i & req_ready_q;
        wr       = acc & req_we_i;
        // offsets wrap below the base, so one compare bounds both ends
        off_live = req_addr_i - ADDR_W'(PERF_LIVE_BASE);
        off_snap = req_addr_i - ADDR_W'(PERF_SNAP_BASE);
        hit_ctrl = req_addr_i == ADDR_W'(PERF_CTRL_ADDR);
        hit_en   = req_addr_i == ADDR_W'(PERF_EN_ADDR);
`ifdef COHORT_PERF_OVERFLOW_IRQ_EN
        hit_ovf  = req_addr_i == ADDR_W'(PERF_OVF_ADDR);
`else
        hit_ovf  = 1'b0;
`endif
        hit_live = off_live < ADDR_W'(NUM_COUNTERS);
        hit_snap = off_snap < ADDR_W'(NUM_COUNTERS);

        clr_all  = wr & hit_ctrl & req_wdata_i[CTRL_CLR_BIT];
        snap_all = wr & hit_ctrl & req_wdata_i[CTRL_SNAP_BIT];

        for (int i = 0; i < NUM_COUNTERS; i++) begin
            load_vec[i]    = wr & hit_live & (off_live == ADDR_W'(i));
            inc_vec[i]     = run_q & en_q[i] & event_i[i];
            ovf_clr_vec[i] = wr & hit_ovf & req_wdata_i[i];
        end

        err_d   = ~(hit_ctrl | hit_en | hit_ovf | hit_live | hit_snap);
        rdata_d = '0;
        if (!req_we_i) begin
            unique case (1'b1)
                hit_ctrl: rdata_d[CTRL_RUN_BIT] = run_q;
                hit_en:   rdata_d[NUM_COUNTERS-1:0] = en_q;
                hit_ovf:  rdata_d[NUM_COUNTERS-1:0] = ovf_vec;
                hit_live: begin
                    for (int i = 0; i < NUM_COUNTERS; i++) begin
                        if (off_live == ADDR_W'(i)) rdata_d = cnt[i];
                    end
                end
                hit_snap: begin
                    for (int i = 0; i < NUM_COUNTERS; i++) begin
                        if (off_snap == ADDR_W'(i)) rdata_d = snap[i];
                    end
                end
                default: rdata_d = '0;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_cell
        perf_counter_cell u_cell (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .clr_i      (clr_all),
            .load_i     (load_vec[g]),
            .load_val_i (req_wdata_i),
            .inc_i      (inc_vec[g]),
            .snap_i     (snap_all),
            .ovf_clr_i  (ovf_clr_vec[g]),
            .cnt_o      (cnt[g]),
            .snap_o     (snap[g]),
            .ovf_o      (ovf_vec[g])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= PERF_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            run_q        <= 1'b0;
            en_q         <= '0;
        end else begin
            unique case (state_q)
                PERF_IDLE: begin
                    if (acc) begin
                        state_q      <= PERF_RESP;
                        req_ready_q  <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= rdata_d;
                        resp_err_q   <= err_d;
                        if (req_we_i && hit_ctrl) begin
                            run_q <= req_wdata_i[CTRL_RUN_BIT];
                        end
                        if (req_we_i && hit_en) begin
                            en_q <= req_wdata_i[NUM_COUNTERS-1:0];
                        end
                    end
                end
                PERF_RESP: begin
                    if (resp_ready_i) begin
                        state_q      <= PERF_IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: state_q <= PERF_IDLE;
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;

`ifdef COHORT_PERF_OVERFLOW_IRQ_EN
    logic ovf_irq_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_irq_q <= 1'b0;
        end else begin
            ovf_irq_q <= |ovf_vec;
        end
    end

    assign ovf_irq_o = ovf_irq_q;
`else
    logic unused_ovf_vec;
    assign unused_ovf_vec = |ovf_vec;
    assign ovf_irq_o      = 1'b0;
`endif

endmodule

// File: tb/tb_cohort_perf_ctrl.sv
// Self-checking bench for cohort_perf_ctrl: directed steps plus random
// traffic against a behavioural model of the register map.
module tb_cohort_perf_ctrl;

    localparam int N  = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  event_i = '0;
    logic          req_valid = 1'b0;
    logic          req_ready_o;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [63:0]   req_wdata = '0;
    logic          resp_valid_o;
    logic          resp_ready = 1'b1;
    logic [63:0]   resp_rdata_o;
    logic          resp_err_o;
    logic          ovf_irq_o;

    int total = 0;
    int bad   = 0;

    logic [63:0] m_live [N];
    logic [63:0] m_snap [N];
    bit          m_run;
    bit [N-1:0]  m_en;
    bit [N-1:0]  m_ovf;
    bit          ovf_map;

    always #5 clk = ~clk;

    cohort_perf_ctrl #(.NUM_COUNTERS(N), .ADDR_W(AW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .event_i      (event_i),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o),
        .ovf_irq_o    (ovf_irq_o)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_live[i] = '0;
            m_snap[i] = '0;
        end
        m_run = 0;
        m_en  = '0;
        m_ovf = '0;
    endtask

    // One clock edge of the block as seen from the register map.
    task automatic model_cycle(input bit acc, input bit we, input int addr,
                               input logic [63:0] wd, input logic [N-1:0] ev,
                               output logic [63:0] rd, output bit err);
        bit [N-1:0] inc;
        bit         clr;
        int         ld;
        rd  = '0;
        err = 0;
        clr = 0;
        ld  = -1;
        inc = m_run ? (m_en & ev) : '0;
        if (acc) begin
            if (addr == 0) rd = 64'(m_run);
            else if (addr == 1) rd = 64'(m_en);
            else if (addr == 2 && ovf_map) rd = 64'(m_ovf);
            else if (addr >= 32 && addr < 32 + N) rd = m_live[addr-32];
            else if (addr >= 64 && addr < 64 + N) rd = m_snap[addr-64];
            else err = 1;
            if (we) rd = '0;
            if (we && !err) begin
                if (addr == 0) begin
                    m_run = wd[0];
                    clr   = wd[1];
                    if (wd[2]) begin
                        for (int i = 0; i < N; i++) m_snap[i] = m_live[i];
                    end
                end else if (addr == 1) begin
                    m_en = wd[N-1:0];
                end else if (addr == 2) begin
                    m_ovf = m_ovf & ~wd[N-1:0];
                end else if (addr < 64) begin
                    ld = addr - 32;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (clr) begin
                m_live[i] = '0;
            end else if (ld == i) begin
                m_live[i] = wd;
            end else if (inc[i]) begin
                if (m_live[i] == 64'hFFFF_FFFF_FFFF_FFFF && ovf_map) m_ovf[i] = 1;
                m_live[i] = m_live[i] + 64'd1;
            end
        end
    endtask

    task automatic req(input bit we, input int addr, input logic [63:0] wd,
                       input logic [N-1:0] ev, input string tag,
                       output logic [63:0] rd);
        logic [63:0] er;
        bit          ee;
        @(negedge clk);
        check({tag, ".rdy"}, 64'(req_ready_o), 64'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = AW'(addr);
        req_wdata = wd;
        event_i   = ev;
        model_cycle(1, we, addr, wd, ev, er, ee);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        event_i   = '0;
        rd        = resp_rdata_o;
        check({tag, ".vld"}, 64'(resp_valid_o), 64'd1);
        check({tag, ".data"}, resp_rdata_o, er);
        check({tag, ".err"}, 64'(resp_err_o), 64'(ee));
        @(posedge clk);
        #1;
        check({tag, ".irq"}, 64'(ovf_irq_o), 64'(ovf_map && (m_ovf != '0)));
    endtask

    task automatic ev_cycle(input logic [N-1:0] ev);
        logic [63:0] er;
        bit          ee;
        @(negedge clk);
        event_i = ev;
        model_cycle(0, 0, 0, '0, ev, er, ee);
        @(posedge clk);
        #1;
        event_i = '0;
    endtask

    initial begin
        logic [63:0] rd;
        logic [63:0] held;
        logic [63:0] er;
        bit          ee;
        int          a;
        int          k;
        logic [63:0] wd;
`ifdef COHORT_PERF_OVERFLOW_IRQ_EN
        ovf_map = 1;
`else
        ovf_map = 0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst.rdy", 64'(req_ready_o), 64'd1);
        check("rst.vld", 64'(resp_valid_o), 64'd0);
        check("rst.data", resp_rdata_o, 64'd0);
        check("rst.err", 64'(resp_err_o), 64'd0);
        check("rst.irq", 64'(ovf_irq_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        req(0, 'h20, 0, 0, "rd_live0", rd);
        req(0, 'h10, 0, 0, "rd_unmapped", rd);
        check("unmapped.err_lit", 64'(resp_err_o), 64'd0);

        req(1, 'h01, 64'h1, 0, "wr_en", rd);
        req(1, 'h00, 64'h1, 0, "wr_run", rd);
        repeat (5) ev_cycle(8'b0000_0011);
        req(0, 'h20, 0, 0, "live0_5", rd);
        check("live0_5.lit", rd, 64'd5);
        req(0, 'h21, 0, 0, "live1_0", rd);
        check("live1_0.lit", rd, 64'd0);

        req(1, 'h22, 64'hFFFF_FFFF_FFFF_FFFE, 0, "pre2", rd);
        req(1, 'h01, 64'h5, 0, "en2", rd);
        repeat (3) ev_cycle(8'b0000_0100);
        req(0, 'h22, 0, 0, "live2_wrap", rd);
        check("live2_wrap.lit", rd, 64'd1);
        req(0, 'h02, 0, 0, "ovf_rd", rd);
        req(1, 'h02, 64'h4, 0, "ovf_w1c", rd);
        req(0, 'h02, 0, 0, "ovf_rd2", rd);

        req(1, 'h20, 64'd100, 0, "pre0_100", rd);
        req(1, 'h00, 64'h5, 0, "snap", rd);
        repeat (10) ev_cycle(8'b0000_0001);
        req(0, 'h40, 0, 0, "snap0", rd);
        check("snap0.lit", rd, 64'd100);
        req(0, 'h20, 0, 0, "live0_110", rd);
        check("live0_110.lit", rd, 64'd110);
        req(1, 'h00, 64'h3, 0, "clr", rd);
        req(0, 'h20, 0, 0, "live0_clr", rd);
        check("live0_clr.lit", rd, 64'd0);
        req(0, 'h40, 0, 0, "snap0_kept", rd);
        check("snap0_kept.lit", rd, 64'd100);

        req(1, 'h20, 64'd7, 8'h01, "pre_ev", rd);
        req(0, 'h20, 0, 0, "pre_ev_rd", rd);
        check("pre_ev.lit", rd, 64'd7);
        req(1, 'h00, 64'h3, 8'h01, "clr_ev", rd);
        req(0, 'h20, 0, 0, "clr_ev_rd", rd);
        check("clr_ev.lit", rd, 64'd0);
        req(1, 'h41, 64'd9, 0, "snap_wr_ign", rd);
        req(0, 'h41, 0, 0, "snap_wr_rd", rd);
        req(0, 'h20 + N, 0, 0, "live_oob", rd);

        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 9) < 4) begin
                ev_cycle(N'($urandom));
            end else begin
                k = int'($urandom_range(0, N - 1));
                case ($urandom_range(0, 6))
                    0: begin a = 0; wd = 64'($urandom_range(0, 7)) | 64'(($urandom_range(0, 3) != 0)); end
                    1: begin a = 1; wd = {$urandom(), $urandom()}; end
                    2: begin a = 2; wd = 64'($urandom); end
                    3: begin
                        a  = 'h20 + k;
                        wd = ($urandom_range(0, 1) == 1) ?
                             (64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15))) :
                             {$urandom(), $urandom()};
                    end
                    4: begin a = 'h40 + k; wd = 64'($urandom); end
                    5: begin a = 'h20 + k; wd = 0; end
                    default: begin a = int'($urandom_range(0, 255)); wd = {$urandom(), $urandom()}; end
                endcase
                req(bit'($urandom_range(0, 1)), a, wd, N'($urandom), "rand", rd);
            end
        end

        req(1, 'h00, 64'h1, 0, "stall_run", rd);
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 8'h20;
        model_cycle(1, 0, 'h20, 0, 0, er, ee);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        held      = resp_rdata_o;
        check("stall.data0", held, er);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check("stall.data", resp_rdata_o, held);
            check("stall.rdy", 64'(req_ready_o), 64'd0);
            check("stall.vld", 64'(resp_valid_o), 64'd1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.vld", 64'(resp_valid_o), 64'd0);
        check("abort.rdy", 64'(req_ready_o), 64'd1);
        check("abort.data", resp_rdata_o, 64'd0);
        model_reset();
        @(negedge clk);
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        req(0, 'h20, 0, 0, "post_rst_live", rd);
        req(0, 'h40, 0, 0, "post_rst_snap", rd);
        req(0, 'h00, 0, 0, "post_rst_ctrl", rd);
        req(0, 'h01, 0, 0, "post_rst_en", rd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
